// File: rtl/serial_tx.sv
// serial_tx: parallel-in, serial-out UART-style transmitter.
// Frame: start bit (0), DATA_W data bits LSB first, optional even-parity bit, stop bit (1).
// Each bit is held for CLKS_PER_BIT clock cycles. A word is accepted on a rising edge
// where valid_in && ready_out; ready_out is high only while idle.
// Optional feature: define SERIAL_TX_PARITY_EN to insert the even-parity bit.
module serial_tx #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic              tx_out,
    output logic              busy_out,
    output logic              done_out
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              done_q, done_d;
    logic              bit_end;
`ifdef SERIAL_TX_PARITY_EN
    logic              par_q, par_d;
`endif

    assign bit_end = (cnt_q == CNT_LAST);

    // Next-state logic; tx_d is the line level for the state being entered,
    // so tx_out is registered yet changes on the same edge as the state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (valid_in) begin
                    state_d = StStart;
                    cnt_d   = '0;
                    idx_d   = '0;
                    shift_d = data_in;
                    tx_d    = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
                    par_d   = ^data_in;
`endif
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                    cnt_d   = '0;
                    tx_d    = shift_q[0];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StData: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_d = StParity;
                        tx_d    = par_q;
`else
                        state_d = StStop;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        shift_d = shift_q >> 1;
                        idx_d   = idx_q + IDX_W'(1);
                        tx_d    = shift_d[0];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            StStop: begin
                if (bit_end) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
            end
        endcase
    end

    // State and datapath registers; reset aborts any frame in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
`ifdef SERIAL_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign ready_out = (state_q == StIdle);
    assign busy_out  = ~ready_out;
    assign tx_out    = tx_q;
    assign done_out  = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx (DATA_W=8, CLKS_PER_BIT=4).
// A per-cycle scoreboard queue holds the expected {tx, busy, done} for every cycle
// of each accepted frame; a vector table adds done-timing and parity/stop checks.
module tb_serial_tx;

    localparam int DW  = 8;
    localparam int CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int F = (2 + DW + P) * CPB;

    logic          clk;
    logic          reset;
    logic [DW-1:0] data_in;
    logic          valid_in;
    logic          ready_out;
    logic          tx_out;
    logic          busy_out;
    logic          done_out;

    serial_tx #(
        .DATA_W      (DW),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .valid_in (valid_in),
        .ready_out(ready_out),
        .tx_out   (tx_out),
        .busy_out (busy_out),
        .done_out (done_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic tx;
        logic busy;
        logic done;
    } rec_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          par;
        int            done_at;
    } vec_t;

    rec_t exp_q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    int   accept_cnt = 0;
    int   accept_cyc = 0;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    // Expected line/status for every cycle of one frame plus the done cycle.
    function automatic void push_frame(input logic [DW-1:0] d);
        rec_t r;
        r.busy = 1'b1;
        r.done = 1'b0;
        r.tx   = 1'b0;
        for (int c = 0; c < CPB; c++) exp_q.push_back(r);
        for (int b = 0; b < DW; b++) begin
            r.tx = d[b];
            for (int c = 0; c < CPB; c++) exp_q.push_back(r);
        end
        if (P == 1) begin
            r.tx = ^d;
            for (int c = 0; c < CPB; c++) exp_q.push_back(r);
        end
        r.tx = 1'b1;
        for (int c = 0; c < CPB; c++) exp_q.push_back(r);
        r.busy = 1'b0;
        r.done = 1'b1;
        exp_q.push_back(r);
    endfunction

    // Reference acceptance: only when the model has no frame outstanding.
    always @(posedge clk) begin
        cyc++;
        if (!reset && valid_in === 1'b1 && exp_q.size() == 0) begin
            push_frame(data_in);
            accept_cnt++;
            accept_cyc = cyc;
        end
    end

    // Per-cycle comparison against the scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        rec_t r;
        r.tx = 1'b1;
        r.busy = 1'b0;
        r.done = 1'b0;
        if (reset) exp_q.delete();
        else if (exp_q.size() > 0) r = exp_q.pop_front();
        check("sb_tx", int'(tx_out), int'(r.tx));
        check("sb_busy", int'(busy_out), int'(r.busy));
        check("sb_ready", int'(ready_out), int'(!r.busy));
        check("sb_done", int'(done_out), int'(r.done));
    end

    task automatic wait_accept(input int target);
        for (int i = 0; i < 200 && accept_cnt < target; i++) begin
            @(posedge clk);
            #1;
        end
        check("accept_timeout", int'(accept_cnt >= target), 1);
    endtask

    task automatic send(input logic [DW-1:0] d);
        int prev;
        @(negedge clk);
        data_in  = d;
        valid_in = 1'b1;
        prev = accept_cnt;
        wait_accept(prev + 1);
        valid_in = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        check("idle_timeout", int'(exp_q.size() == 0), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        int   a5_seq[$];
        int   c1;
        int   c2;
        int   prev;
        bit   seen;

        vecs = '{'{8'hA5, 1'b0, F}, '{8'h07, 1'b1, F}, '{8'h00, 1'b0, F},
                 '{8'hFF, 1'b0, F}, '{8'h3C, 1'b0, F}, '{8'h5A, 1'b0, F},
                 '{8'h80, 1'b1, F}};
`ifdef SERIAL_TX_PARITY_EN
        a5_seq = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
`else
        a5_seq = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
`endif

        reset    = 1'b1;
        valid_in = 1'b1;  // must not be accepted while in reset
        data_in  = 8'hC3;
        repeat (3) @(negedge clk);
        valid_in = 1'b0;
        reset    = 1'b0;

        // Idle after release: scoreboard expects idle levels every cycle.
        repeat (20) @(negedge clk);

        // Table: done timing, parity bit and stop bit per word; bit pattern for 0xA5.
        foreach (vecs[e]) begin
            send(vecs[e].data);
            seen = 1'b0;
            for (int off = 0; off < 100; off++) begin
                @(negedge clk);
                if (e == 0 && off % CPB == 2 && off / CPB < a5_seq.size())
                    check("a5_bit", int'(tx_out), a5_seq[off / CPB]);
`ifdef SERIAL_TX_PARITY_EN
                if (off == (1 + DW) * CPB + 2)
                    check("parity_bit", int'(tx_out), int'(vecs[e].par));
`endif
                if (off == (1 + DW + P) * CPB + 2)
                    check("stop_bit", int'(tx_out), 1);
                if (done_out === 1'b1) begin
                    check("done_cycle", off, vecs[e].done_at);
                    seen = 1'b1;
                    break;
                end
            end
            if (!seen) check("done_seen", 0, 1);
            wait_idle();
        end

        // Back-to-back with valid held; data_in wiggles mid-frame.
        @(negedge clk);
        data_in  = 8'h00;
        valid_in = 1'b1;
        prev = accept_cnt;
        wait_accept(prev + 1);
        c1 = accept_cyc;
        data_in = 8'hFF;
        repeat (10) @(negedge clk);
        data_in = 8'h55;
        @(negedge clk);
        data_in = 8'hFF;
        wait_accept(prev + 2);
        c2 = accept_cyc;
        valid_in = 1'b0;
        data_in  = 8'h81;
        // Ready rises one edge after the last stop cycle; the next start follows at once.
        check("b2b_gap", c2 - c1, F + 1);
        wait_idle();

        // valid_in pulsed during DATA of 0xA5 must be ignored.
        send(8'hA5);
        repeat (14) @(negedge clk);
        data_in  = 8'h3C;
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        wait_idle();
        repeat (8) @(negedge clk);

        // Asynchronous reset mid-DATA, then a fresh frame.
        send(8'hA5);
        repeat (16) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("rst_tx", int'(tx_out), 1);
        check("rst_ready", int'(ready_out), 1);
        check("rst_busy", int'(busy_out), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        send(8'h5A);
        wait_idle();
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
